// File: rtl/reg_nto1_mux_pipe_if.sv
// Handshake bundle for reg_nto1_mux_pipe: input lanes/select, output value, sticky error.
// neg_in exists only when REG_MUX_NEG_EN is defined.
interface reg_nto1_mux_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] d_in;
  logic [SEL_W-1:0]        sel_in;
`ifdef REG_MUX_NEG_EN
  logic                    neg_in;
`endif
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] y_output;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

`ifdef REG_MUX_NEG_EN
  modport master (
    output d_in, sel_in, neg_in, in_valid, out_ready,
    input  in_ready, y_output, out_valid, sel_err
  );
  modport slave (
    input  d_in, sel_in, neg_in, in_valid, out_ready,
    output in_ready, y_output, out_valid, sel_err
  );
`else
  modport master (
    output d_in, sel_in, in_valid, out_ready,
    input  in_ready, y_output, out_valid, sel_err
  );
  modport slave (
    input  d_in, sel_in, in_valid, out_ready,
    output in_ready, y_output, out_valid, sel_err
  );
`endif
endinterface

// File: rtl/reg_nto1_mux_pipe.sv
// Registered N-to-1 signed operand mux with optional saturating negation (REG_MUX_NEG_EN).
// Latency: one cycle from input transfer to out_valid; one transfer per cycle sustained.
// Backpressure: two-entry skid (OR + SK); in_ready is a flop, no path from out_ready.
module reg_nto1_mux_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_nto1_mux_pipe_if.slave   bus
);

  logic signed [WIDTH-1:0] sel_val;
  logic signed [WIDTH-1:0] cap_val;
  logic                    sel_oor;
  logic                    in_xfer;
  logic                    out_xfer;

  logic                    or_vld_q,  or_vld_d;
  logic signed [WIDTH-1:0] or_dat_q,  or_dat_d;
  logic                    sk_vld_q,  sk_vld_d;
  logic signed [WIDTH-1:0] sk_dat_q,  sk_dat_d;
  logic                    in_rdy_q,  in_rdy_d;
  logic                    sel_err_q, sel_err_d;

`ifdef REG_MUX_NEG_EN
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  // Unmatched (out-of-range) selects fall through to zero.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (32'(bus.sel_in) == i) begin
        sel_val = bus.d_in[i*WIDTH +: WIDTH];
      end
    end
    sel_oor = (32'(bus.sel_in) >= NUM_IN);
  end

  always_comb begin
`ifdef REG_MUX_NEG_EN
    if (!bus.neg_in) begin
      cap_val = sel_val;
    end else if (sel_val == S_MIN) begin
      cap_val = S_MAX;
    end else begin
      cap_val = -sel_val;
    end
`else
    cap_val = sel_val;
`endif
  end

  assign in_xfer  = bus.in_valid && in_rdy_q;
  assign out_xfer = or_vld_q && bus.out_ready;

  always_comb begin
    or_vld_d  = or_vld_q;
    or_dat_d  = or_dat_q;
    sk_vld_d  = sk_vld_q;
    sk_dat_d  = sk_dat_q;
    sel_err_d = sel_err_q || (in_xfer && sel_oor);

    if (!or_vld_q || (out_xfer && !sk_vld_q)) begin
      or_vld_d = in_xfer;
      if (in_xfer) begin
        or_dat_d = cap_val;
      end
    end else if (out_xfer) begin
      // SK is full here: promote it and let any concurrent input refill SK.
      or_dat_d = sk_dat_q;
      sk_vld_d = in_xfer;
      if (in_xfer) begin
        sk_dat_d = cap_val;
      end
    end else if (in_xfer) begin
      sk_vld_d = 1'b1;
      sk_dat_d = cap_val;
    end

    in_rdy_d = !sk_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_vld_q  <= 1'b0;
      or_dat_q  <= '0;
      sk_vld_q  <= 1'b0;
      sk_dat_q  <= '0;
      in_rdy_q  <= 1'b1;
      sel_err_q <= 1'b0;
    end else begin
      or_vld_q  <= or_vld_d;
      or_dat_q  <= or_dat_d;
      sk_vld_q  <= sk_vld_d;
      sk_dat_q  <= sk_dat_d;
      in_rdy_q  <= in_rdy_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = or_vld_q;
  assign bus.y_output  = or_dat_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/reg_nto1_mux_pipe.md
# reg_nto1_mux_pipe

Parametrised, registered N-to-1 signed operand multiplexer with a valid/ready handshake and a two-entry skid buffer, so it sustains one transfer per cycle under backpressure. It selects the operand that feeds each CORDIC iteration stage (x, y or z path, or a shifted variant) from up to NUM_IN candidate lanes. It is the pipelined, stallable successor to the combinational 2-to-1 operand mux, and adds out-of-range select detection and optional negation.

## Interface
- WIDTH, default 8: signed data width of each lane and of the output.
- NUM_IN, default 4: number of input lanes; legal range 2..16.
- SEL_W, default $clog2(NUM_IN): select width; derived, never overridden.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- d_in  in  NUM_IN*WIDTH  packed lanes; lane i occupies bits [i*WIDTH +: WIDTH], each signed.
- sel_in  in  SEL_W  lane index, sampled on input transfer.
- neg_in  in  1  negate the selected lane; present only with REG_MUX_NEG_EN.
- in_valid  in  1  upstream presents d_in/sel_in/neg_in.
- in_ready  out  1  block can accept a transfer.
- y_output  out  WIDTH  signed selected (optionally negated) value.
- out_valid  out  1  y_output holds valid data.
- out_ready  in  1  downstream accepts y_output.
- sel_err  out  1  sticky: an accepted transfer had sel_in >= NUM_IN.

## Operation
- Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Storage: an output register (OR) and a skid register (SK), each holding data plus a valid bit.
- Selection is computed combinationally from the live inputs and captured on input transfer; no combinational path from d_in to y_output.
- sel_in >= NUM_IN (only possible when NUM_IN is not a power of two): the captured value is 0, the transfer still completes, and sel_err sets and stays set until reset.
- Per cycle, in priority order:
  - OR empty, or output transfer with SK empty: an input transfer loads OR.
  - Output transfer with SK full: SK moves to OR and SK empties. A same-cycle input transfer loads SK.
  - OR full, no output transfer: an input transfer loads SK.
- in_ready = !SK.valid, driven from a register with no combinational path from out_ready.
- Data is delivered in acceptance order. Nothing is dropped or duplicated.
- in_valid and out_ready may change on any cycle. Inputs are sampled only at transfer, so upstream changing d_in while in_ready=0 has no effect.

## Timing
- Reset values (asynchronous, immediate): out_valid=0, y_output=0, in_ready=1, sel_err=0, SK.valid=0.
- Latency: an input transfer at edge N gives out_valid=1 with the value after edge N, i.e. visible in cycle N+1.
- Throughput: one transfer per cycle while out_ready=1.
- Backpressure: after out_ready drops, at most one further input is accepted into SK. in_ready falls on the next cycle.
- When out_ready rises again with SK full, OR takes SK's entry and in_ready returns to 1 one cycle later.
- Reset asserted mid-stream clears both entries. In-flight data is discarded and no partial output appears.

## Configuration
- Macro REG_MUX_NEG_EN.
- Defined:
  - neg_in exists and is captured with the data.
  - When neg_in=1, the stored value is the two's-complement negation of the selected lane.
  - Negation saturates: -2^(WIDTH-1) maps to 2^(WIDTH-1)-1.
  - An out-of-range select still yields 0.
- Undefined: neg_in is absent and the value is the selected lane unmodified.

## Test plan
- Basic select, WIDTH=8, NUM_IN=4, lanes {30,45,-7,-128}, out_ready=1: sel 0,1,2,3 on consecutive cycles -> y_output 30,45,-7,-128 one cycle after each acceptance, out_valid high continuously.
- Backpressure: stream 1,2,3,4 with out_ready held 0 from cycle 2 for 3 cycles -> in_ready falls after value 2 is accepted; outputs 1,2,3,4 in order, none lost or duplicated.
- Out of range, NUM_IN=3: sel_in=3 with lanes {5,6,7} -> y_output=0, sel_err=1 and stays 1 through later valid transfers until rst_n=0.
- Negation, REG_MUX_NEG_EN defined: sel of 45 with neg_in=1 -> -45; sel of -128 with neg_in=1 -> 127.
- Reset mid-operation: SK and OR both full, drive rst_n=0 asynchronously between edges -> out_valid=0, y_output=0, in_ready=1 immediately; no stale data after release.
- Random stress: random in_valid/out_ready at 50% for 10k cycles against a FIFO scoreboard -> exact order match and in_ready never deasserted while SK is empty.
